// File: rtl/conv_sequencer.sv
// Control FSM for the 3x3 binary-convolution engine: loads the kernel, slides a 3-row
// window over each SRAM image, streams column slices out and packs the returned signs into row words.
//
// state    | meaning
// IDLE     | waiting for dut_run
// WFETCH   | weight memory address 1 presented
// WLOAD    | kernel word arrives, latched; load_weights pulses next cycle
// HDR      | nrows address presented
// HDR_N    | nrows arrives; end marker check; ncols address presented
// HDR_C    | ncols arrives; choose SKIP or FILL
// SKIP     | degenerate image, jump read pointer over its rows
// FILL     | read first three rows into the window
// STREAM   | one column slice per cycle to the conv array
// COLLECT  | gather sign results until the last window column reports
// WRITE    | one output row word written
// ADVANCE  | request next image row, or back to HDR when the image is done
// ADV_WAIT | shift the new row into the window
// DONE     | end of run, busy drops next cycle
module conv_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter logic [DATA_W-1:0] END_MARKER = 16'h00FF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic              load_weights,
    output logic [8:0]        weights_data,
    output logic              conv_go,
    output logic [2:0]        d_in,
    output logic [3:0]        coli_in,
    input  logic              res_valid,
    input  logic [3:0]        res_col,
    input  logic              res_neg
);

    typedef enum logic [3:0] {
        IDLE, WFETCH, WLOAD, HDR, HDR_N, HDR_C, SKIP, FILL,
        STREAM, COLLECT, WRITE, ADVANCE, ADV_WAIT, DONE
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] rd_ptr, wr_ptr, nrows_r, rows_left;
    logic [4:0]        ncols_r;
    logic [3:0]        col;
    logic [1:0]        fill_cnt;
    logic              small_r, lw_r;
    logic [8:0]        wt_r;
    logic [DATA_W-1:0] row0, row1, row2, acc, mask;
    logic              is_end, hdr_small, last_col, trig;
    logic              unused_wmem;

    assign is_end    = (sram_dut_read_data == END_MARKER);
    assign hdr_small = (sram_dut_read_data < DATA_W'(3));
    assign last_col  = ({1'b0, col} == (ncols_r - 5'd1));
    assign trig      = res_valid && ({1'b0, res_col} == (ncols_r - 5'd3));
    // only ncols-2 windows exist per row; higher accumulator bits are never valid output
    assign mask      = (DATA_W'(1) << (ncols_r - 5'd2)) - DATA_W'(1);
    assign unused_wmem = ^wmem_dut_read_data[DATA_W-1:9];

    assign dut_sram_read_address  = rd_ptr;
    assign dut_sram_write_address = wr_ptr;
    assign load_weights           = lw_r;
    assign weights_data           = wt_r;
    assign dut_busy               = (state != IDLE);

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            nrows_r   <= '0;
            rows_left <= '0;
            ncols_r   <= '0;
            col       <= '0;
            fill_cnt  <= '0;
            small_r   <= 1'b0;
            lw_r      <= 1'b0;
            wt_r      <= '0;
            row0      <= '0;
            row1      <= '0;
            row2      <= '0;
            acc       <= '0;
        end else begin
            state <= next_state;
            lw_r  <= (state == WLOAD);
            case (state)
                IDLE: if (dut_run) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    acc    <= '0;
                end
                WLOAD: wt_r <= wmem_dut_read_data[8:0];
                HDR:   rd_ptr <= rd_ptr + ADDR_W'(1);
                HDR_N: if (!is_end) begin
                    nrows_r <= sram_dut_read_data[ADDR_W-1:0];
                    small_r <= hdr_small;
                    rd_ptr  <= rd_ptr + ADDR_W'(1);
                end
                HDR_C: begin
                    ncols_r  <= sram_dut_read_data[4:0];
                    fill_cnt <= '0;
                end
                SKIP: rd_ptr <= rd_ptr + nrows_r;
                FILL: begin
                    if (fill_cnt != 2'd3)
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                    if (fill_cnt != 2'd0) begin
                        row0 <= row1;
                        row1 <= row2;
                        row2 <= sram_dut_read_data;
                    end
                    fill_cnt <= fill_cnt + 2'd1;
                    if (fill_cnt == 2'd3) begin
                        col       <= '0;
                        rows_left <= nrows_r - ADDR_W'(3);
                    end
                end
                STREAM:  col <= col + 4'd1;
                COLLECT: if (res_valid) acc[res_col] <= res_neg;
                WRITE: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    acc    <= '0;
                end
                ADVANCE: if (rows_left != '0) begin
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                    rows_left <= rows_left - ADDR_W'(1);
                end
                ADV_WAIT: begin
                    row0 <= row1;
                    row1 <= row2;
                    row2 <= sram_dut_read_data;
                    col  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state            = state;
        dut_wmem_read_address = '0;
        dut_sram_write_enable = 1'b0;
        dut_sram_write_data   = '0;
        conv_go               = 1'b0;
        d_in                  = '0;
        coli_in               = '0;
        case (state)
            IDLE:    if (dut_run) next_state = WFETCH;
            WFETCH: begin
                dut_wmem_read_address = ADDR_W'(1);
                next_state = WLOAD;
            end
            WLOAD:   next_state = HDR;
            HDR:     next_state = HDR_N;
            HDR_N:   next_state = is_end ? DONE : HDR_C;
            HDR_C:   next_state = (small_r || hdr_small) ? SKIP : FILL;
            SKIP:    next_state = HDR;
            FILL:    if (fill_cnt == 2'd3) next_state = STREAM;
            STREAM: begin
                conv_go = 1'b1;
                d_in    = {row2[col], row1[col], row0[col]};
                coli_in = col;
                if (last_col) next_state = COLLECT;
            end
            COLLECT: if (trig) next_state = WRITE;
            WRITE: begin
                dut_sram_write_enable = 1'b1;
                dut_sram_write_data   = acc & mask;
                next_state = ADVANCE;
            end
            ADVANCE:  next_state = (rows_left == '0) ? HDR : ADV_WAIT;
            ADV_WAIT: next_state = STREAM;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: image memories are built from random/directed tables,
// a responder plays the adder tree, and monitors compare streams and writes against the model.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        dut_run = 1'b0;
    logic        dut_busy;
    logic [11:0] dut_sram_read_address;
    logic [15:0] sram_dut_read_data = '0;
    logic [11:0] dut_wmem_read_address;
    logic [15:0] wmem_dut_read_data = '0;
    logic [11:0] dut_sram_write_address;
    logic [15:0] dut_sram_write_data;
    logic        dut_sram_write_enable;
    logic        load_weights;
    logic [8:0]  weights_data;
    logic        conv_go;
    logic [2:0]  d_in;
    logic [3:0]  coli_in;
    logic        res_valid = 1'b0;
    logic [3:0]  res_col = '0;
    logic        res_neg = 1'b0;

    conv_sequencer dut (
        .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .dut_busy(dut_busy),
        .dut_sram_read_address(dut_sram_read_address), .sram_dut_read_data(sram_dut_read_data),
        .dut_wmem_read_address(dut_wmem_read_address), .wmem_dut_read_data(wmem_dut_read_data),
        .dut_sram_write_address(dut_sram_write_address), .dut_sram_write_data(dut_sram_write_data),
        .dut_sram_write_enable(dut_sram_write_enable), .load_weights(load_weights),
        .weights_data(weights_data), .conv_go(conv_go), .d_in(d_in), .coli_in(coli_in),
        .res_valid(res_valid), .res_col(res_col), .res_neg(res_neg)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] data; int cyc; } wr_t;

    logic [15:0] sram [0:4095];
    logic [15:0] wmem [0:4095];
    logic [6:0]  exp_stream [$];
    wr_t         exp_wr [$];
    logic [15:0] wr_log [$];
    logic [3:0]  dir_col [$];
    logic        dir_neg [$];
    logic [3:0]  pend_col [$];
    logic        pend_neg [$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, wp = 0, exp_total = 0, exp_waddr = 0, lw_cnt = 0, busy_cyc = 0;
    int s_len = 0, m_nc = 0;
    logic [15:0] m_acc, msk;
    logic [8:0]  lw_val;
    logic        stray = 1'b0;
    logic [3:0]  r_c;
    logic        r_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        sram_dut_read_data <= sram[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    always @(negedge clk) begin
        if (conv_go) begin
            if (exp_stream.size() == 0) chk("unexpected_conv_go", 32'(conv_go), 32'd0);
            else chk("stream_slice", 32'({coli_in, d_in}), 32'(exp_stream.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (dut_sram_write_enable) begin
            wr_log.push_back(dut_sram_write_data);
            if (exp_wr.size() == 0) chk("unexpected_write", 32'(dut_sram_write_enable), 32'd0);
            else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_data", 32'(dut_sram_write_data), 32'(e.data));
                chk("wr_addr", 32'(dut_sram_write_address), 32'(exp_waddr));
                chk("wr_timing", 32'(cyc), 32'(e.cyc));
            end
            exp_waddr++;
        end
    end

    always @(negedge clk) begin
        if (load_weights) begin
            lw_cnt++;
            lw_val = weights_data;
            chk("weights_data", 32'(weights_data), 32'(wmem[1][8:0]));
        end
    end

    task automatic build_pending();
        int ord[16];
        int nw, j, t;
        nw = m_nc - 2;
        if (dir_col.size() > 0) begin
            while (dir_col.size() > 0) begin
                r_c = dir_col.pop_front();
                pend_col.push_back(r_c);
                pend_neg.push_back(dir_neg.pop_front());
                if (int'(r_c) == m_nc - 3) break;
            end
        end else begin
            for (int i = 0; i < nw; i++) ord[i] = i;
            for (int i = nw - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int i = 0; i < nw; i++) begin
                // results for columns past the last window must never reach the output word
                if ($urandom_range(0, 3) == 0) begin
                    pend_col.push_back(4'($urandom_range(nw, 15)));
                    pend_neg.push_back(1'b1);
                end
                pend_col.push_back(4'(ord[i]));
                pend_neg.push_back(1'($urandom_range(0, 1)));
            end
        end
    endtask

    // adder-tree stand-in: answers each finished stream, then one stray result that must be ignored
    always @(negedge clk) begin
        res_valid = 1'b0;
        res_col   = 4'd0;
        res_neg   = 1'b0;
        if (reset_b) begin
            s_len = 0;
            stray = 1'b0;
            pend_col.delete();
            pend_neg.delete();
        end else if (conv_go) begin
            s_len++;
        end else begin
            if (s_len > 0) begin
                m_nc  = s_len;
                s_len = 0;
                m_acc = '0;
                build_pending();
            end
            if (stray) begin
                res_valid = 1'b1; res_col = 4'd0; res_neg = 1'b1;
                stray = 1'b0;
            end else if (pend_col.size() > 0 && $urandom_range(0, 2) != 0) begin
                r_c = pend_col.pop_front();
                r_n = pend_neg.pop_front();
                res_valid = 1'b1; res_col = r_c; res_neg = r_n;
                m_acc[r_c] = r_n;
                if (int'(r_c) == m_nc - 3) begin
                    msk = 16'((32'd1 << (m_nc - 2)) - 32'd1);
                    exp_wr.push_back('{data: m_acc & msk, cyc: cyc + 1});
                    pend_col.delete();
                    pend_neg.delete();
                    stray = 1'b1;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            sram[i] = 16'h0000;
            wmem[i] = 16'($urandom);
        end
        exp_stream.delete();
        exp_wr.delete();
        dir_col.delete();
        dir_neg.delete();
        exp_total = 0;
        wp = 0;
    endtask

    task automatic add_image(input int nr, input int nc, input logic [15:0] fixval, input bit use_fix);
        logic [15:0] rows [16];
        sram[wp] = 16'(nr);
        sram[wp + 1] = 16'(nc);
        wp += 2;
        for (int r = 0; r < nr; r++) begin
            rows[r] = use_fix ? fixval : 16'($urandom);
            sram[wp] = rows[r];
            wp++;
        end
        if (nr >= 3 && nc >= 3) begin
            for (int r = 0; r <= nr - 3; r++)
                for (int c = 0; c < nc; c++)
                    exp_stream.push_back({4'(c), rows[r + 2][c], rows[r + 1][c], rows[r][c]});
            exp_total += nr - 2;
        end
    endtask

    task automatic do_run(input bit pulse_mid);
        int t;
        sram[wp] = 16'h00FF;
        wr_log.delete();
        lw_cnt = 0;
        exp_waddr = 0;
        busy_cyc = 0;
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        chk("busy_rise", 32'(dut_busy), 32'd1);
        t = 0;
        while (dut_busy && t < 5000) begin
            busy_cyc++;
            @(negedge clk);
            t++;
            dut_run = (pulse_mid && t == 6);
        end
        dut_run = 1'b0;
        if (t >= 5000) chk("busy_timeout", 32'(dut_busy), 32'd0);
        chk("write_count", 32'(wr_log.size()), 32'(exp_total));
        chk("stream_left", 32'(exp_stream.size()), 32'd0);
        chk("load_weights_count", 32'(lw_cnt), 32'd1);
        repeat (4) @(negedge clk);
        chk("busy_stays_low", 32'(dut_busy), 32'd0);
        chk("no_late_write", 32'(wr_log.size()), 32'(exp_total));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 32'(dut_busy), 32'd0);
        chk({tag, "_we"}, 32'(dut_sram_write_enable), 32'd0);
        chk({tag, "_conv_go"}, 32'(conv_go), 32'd0);
        chk({tag, "_rd_addr"}, 32'(dut_sram_read_address), 32'd0);
        chk({tag, "_wr_addr"}, 32'(dut_sram_write_address), 32'd0);
        chk({tag, "_load_w"}, 32'({load_weights, weights_data}), 32'd0);
    endtask

    initial begin
        int t;
        clear_mem();
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset_b = 1'b0;
        @(negedge clk);

        // kernel plus one 4x4 image, every result negative
        clear_mem();
        wmem[1] = 16'h01FF;
        add_image(4, 4, 16'h000F, 1'b1);
        for (int i = 0; i < 2; i++) begin
            dir_col.push_back(4'd0); dir_neg.push_back(1'b1);
            dir_col.push_back(4'd1); dir_neg.push_back(1'b1);
        end
        do_run(1'b0);
        chk("t1_writes", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk("t1_word0", 32'(wr_log[0]), 32'h0003);
            chk("t1_word1", 32'(wr_log[1]), 32'h0003);
        end
        chk("t1_kernel", 32'(lw_val), 32'h1FF);

        // immediate terminator
        clear_mem();
        do_run(1'b0);
        chk("t2_writes", 32'(wr_log.size()), 32'd0);
        chk("t2_busy_short", 32'(busy_cyc <= 6), 32'd1);

        // 3x5 then 5x3
        clear_mem();
        add_image(3, 5, 16'h0, 1'b0);
        add_image(5, 3, 16'h0, 1'b0);
        do_run(1'b0);
        chk("t3_writes", 32'(wr_log.size()), 32'd4);

        // degenerate images between valid ones
        clear_mem();
        add_image(4, 6, 16'h0, 1'b0);
        add_image(2, 8, 16'h0, 1'b0);
        add_image(5, 2, 16'h0, 1'b0);
        add_image(3, 4, 16'h0, 1'b0);
        do_run(1'b0);
        chk("t4_writes", 32'(wr_log.size()), 32'd3);

        // out-of-order results, then trigger column arriving first
        clear_mem();
        add_image(4, 5, 16'h0, 1'b0);
        dir_col.push_back(4'd1); dir_neg.push_back(1'b1);
        dir_col.push_back(4'd0); dir_neg.push_back(1'b0);
        dir_col.push_back(4'd2); dir_neg.push_back(1'b1);
        dir_col.push_back(4'd2); dir_neg.push_back(1'b1);
        do_run(1'b0);
        if (wr_log.size() == 2) begin
            chk("t5_ooo_word", 32'(wr_log[0]), 32'h0006);
            chk("t5_first_word", 32'(wr_log[1]), 32'h0004);
        end else chk("t5_writes", 32'(wr_log.size()), 32'd2);

        // reset in the middle of a stream, then restart from address 0
        clear_mem();
        add_image(5, 6, 16'h0, 1'b0);
        sram[wp] = 16'h00FF;
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        t = 0;
        while (!conv_go && t < 200) begin @(negedge clk); t++; end
        chk("t6_stream_started", 32'(conv_go), 32'd1);
        @(negedge clk);
        reset_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("t6_reset");
        end
        reset_b = 1'b0;
        clear_mem();
        add_image(5, 6, 16'h0, 1'b0);
        do_run(1'b0);

        // dut_run pulsed while busy
        clear_mem();
        add_image(5, 5, 16'h0, 1'b0);
        do_run(1'b1);

        for (int it = 0; it < 8; it++) begin
            int nimg;
            clear_mem();
            nimg = int'($urandom_range(1, 3));
            for (int k = 0; k < nimg; k++)
                add_image(int'($urandom_range(0, 7)), int'($urandom_range(0, 16)), 16'h0, 1'b0);
            do_run(it[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
